dcache_port_arbiter: RTL



---
 rtl/dcache_port_arbiter_if.sv | 35 +++
 rtl/dcache_port_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dcache_port_arbiter_if.sv
// Bus bundle between the data-cache port arbiter, its requesters and the BRAM.
//   req_*  : per-requester valid/we/addr/wdata in, one-hot ready out
//   resp_* : one-hot read-data-valid and shared read data out
//   mem_*  : registered BRAM command out, BRAM read data in
// slave modport is the arbiter's view; master is the environment's view.
interface dcache_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 12
);
  logic [NUM_REQ-1:0]        req_valid_in;
  logic [NUM_REQ-1:0]        req_we_in;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_in;
  logic [NUM_REQ*DATA_W-1:0] req_wdata_in;
  logic [NUM_REQ-1:0]        req_ready_out;
  logic [NUM_REQ-1:0]        resp_valid_out;
  logic [DATA_W-1:0]         resp_data_out;
  logic                      mem_en_out;
  logic                      mem_we_out;
  logic [ADDR_W-1:0]         mem_addr_out;
  logic [DATA_W-1:0]         mem_din_out;
  logic [DATA_W-1:0]         mem_dout_in;

  modport slave (
    input  req_valid_in, req_we_in, req_addr_in, req_wdata_in, mem_dout_in,
    output req_ready_out, resp_valid_out, resp_data_out,
    output mem_en_out, mem_we_out, mem_addr_out, mem_din_out
  );

  modport master (
    output req_valid_in, req_we_in, req_addr_in, req_wdata_in, mem_dout_in,
    input  req_ready_out, resp_valid_out, resp_data_out,
    input  mem_en_out, mem_we_out, mem_addr_out, mem_din_out
  );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing one data-cache BRAM port among NUM_REQ requesters
// (0 = SMA/LOADI, 1 = LOADB, 2 = WRITEB). One access per cycle, registered BRAM
// command, read data routed back to the issuer READ_LATENCY cycles after issue.
// Ports:
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   bus (slave)      : request/response/BRAM signals, see dcache_port_arbiter_if
// Optional macro DCACHE_ARB_STATS_EN adds saturating statistics outputs:
//   conflict_count_out : cycles with two or more requests pending
//   grant_count_out    : per-requester handshake counts, 16 bits each
module dcache_port_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned DEPTH        = 4096,
  parameter int unsigned READ_LATENCY = 2,
  localparam int unsigned ADDR_W      = $clog2(DEPTH)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  dcache_port_arbiter_if.slave bus
`ifdef DCACHE_ARB_STATS_EN
  ,
  output logic [15:0]          conflict_count_out,
  output logic [NUM_REQ*16-1:0] grant_count_out
`endif
);

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]    gnt_idx, scan_idx;
  logic [NUM_REQ-1:0] grant;
  logic              hs;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;
  logic [IdW-1:0]    id_q;

  logic [READ_LATENCY-1:0] tag_vld_q;
  logic [IdW-1:0]          tag_id_q [READ_LATENCY];

  // First valid requester at or after rr_ptr, wrapping; ready only goes to valid ones,
  // so every grant is a handshake.
  always_comb begin
    grant    = '0;
    hs       = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = IdW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!hs && bus.req_valid_in[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        hs              = 1'b1;
        gnt_idx         = scan_idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs) begin
      rr_ptr_d = (gnt_idx == IdW'(NUM_REQ - 1)) ? '0 : gnt_idx + IdW'(1);
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_we    = bus.req_we_in[i];
        sel_addr  = bus.req_addr_in[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata_in[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rr_ptr_q   <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      id_q       <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      mem_en_q <= hs;
      mem_we_q <= hs & sel_we;
      if (hs) begin
        mem_addr_q <= sel_addr;
        mem_din_q  <= sel_wdata;
        id_q       <= gnt_idx;
      end
    end
  end

  // Tag stage k is aligned with the BRAM read issued k+1 cycles earlier, so the last
  // stage lines up with mem_dout_in.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tag_vld_q <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) tag_id_q[i] <= '0;
    end else begin
      tag_vld_q[0] <= mem_en_q & ~mem_we_q;
      tag_id_q[0]  <= id_q;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  always_comb begin
    bus.resp_valid_out = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.resp_valid_out[i] = tag_vld_q[READ_LATENCY-1] &&
                              (tag_id_q[READ_LATENCY-1] == IdW'(i));
    end
  end

  assign bus.req_ready_out = grant;
  assign bus.resp_data_out = bus.mem_dout_in;
  assign bus.mem_en_out    = mem_en_q;
  assign bus.mem_we_out    = mem_we_q;
  assign bus.mem_addr_out  = mem_addr_q;
  assign bus.mem_din_out   = mem_din_q;

`ifdef DCACHE_ARB_STATS_EN
  logic [15:0] conflict_q;
  logic [15:0] grant_cnt_q [NUM_REQ];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      conflict_q <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
    end else begin
      if (($countones(bus.req_valid_in) > 1) && (conflict_q != 16'hFFFF)) begin
        conflict_q <= conflict_q + 16'd1;
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (grant_cnt_q[i] != 16'hFFFF)) grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_count_out = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) grant_count_out[i*16 +: 16] = grant_cnt_q[i];
  end

  assign conflict_count_out = conflict_q;
`endif

endmodule
